// File: rtl/placar_pkg.sv
// placar_pkg: shared widths, saturating arithmetic and the undo record type
package placar_pkg;
  localparam int PTS_W = 2;
  localparam int MAX_W = 16;
  localparam int TEAM_W = 8;

  typedef struct packed {
    logic valid;
    logic [TEAM_W-1:0] team;
    logic [MAX_W-1:0] score;
  } undo_t;

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] score, input logic [PTS_W-1:0] pts, input logic [MAX_W-1:0] mx);
    logic [MAX_W:0] s;
    s = {1'b0, score} + (MAX_W+1)'(pts);
    return (s > {1'b0, mx}) ? mx : s[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] score, input logic [PTS_W-1:0] pts);
    return ({1'b0, score} < (MAX_W+1)'(pts)) ? '0 : score - MAX_W'(pts);
  endfunction
endpackage

// File: rtl/placar_multitime_if.sv
// placar_multitime_if: button/undo/preset inputs and score/leader outputs of the scoreboard
interface placar_multitime_if #(
  parameter int N_TEAMS = 2,
  parameter int WIDTH = 7
);
  localparam int LW = ($clog2(N_TEAMS) < 1) ? 1 : $clog2(N_TEAMS);
  logic pr;
  logic chaveNP;
  logic desfazer;
  logic [2*N_TEAMS-1:0] somaBTNs;
  logic [WIDTH*N_TEAMS-1:0] placar;
  logic [N_TEAMS-1:0] evento;
  logic [LW-1:0] lider;
  logic empate;
  modport master (output pr, chaveNP, desfazer, somaBTNs, input placar, evento, lider, empate);
  modport slave (input pr, chaveNP, desfazer, somaBTNs, output placar, evento, lider, empate);
endinterface

// File: rtl/placar_canal.sv
// placar_canal: one team channel with press arming, saturating score and load port
module placar_canal
  import placar_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int MAX_SCORE = 99
) (
  input  logic clock,
  input  logic clr,
  input  logic [PTS_W-1:0] field,
  input  logic sub,
  input  logic apply_en,
  input  logic load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic load_evt,
  output logic [WIDTH-1:0] score,
  output logic evt,
  output logic hit
);
  logic armed;
  logic [WIDTH-1:0] nxt;

  assign nxt = sub ? WIDTH'(sat_sub(MAX_W'(score), field))
                   : WIDTH'(sat_add(MAX_W'(score), field, MAX_W'(MAX_SCORE)));
  assign hit = armed && field != '0 && nxt != score;

  // a press is consumed whenever seen armed; re-arming needs an idle field
  always_ff @(posedge clock) begin
    if (clr) begin
      armed <= 1'b0;
      score <= '0;
      evt <= 1'b0;
    end else begin
      armed <= field == '0;
      score <= load_en ? load_val : (apply_en && hit) ? nxt : score;
      evt <= load_en ? load_evt : apply_en && hit;
    end
  end
endmodule

// File: rtl/placar_multitime.sv
// placar_multitime: N-team saturating scoreboard with one-level undo, preset and leader/tie
module placar_multitime
  import placar_pkg::*;
#(
  parameter int N_TEAMS = 2,
  parameter int WIDTH = 7,
  parameter int MAX_SCORE = 99,
  parameter int PRESET_VAL = 0
) (
  input logic clock,
  input logic clr,
  placar_multitime_if.slave bus
);
  localparam int LW = ($clog2(N_TEAMS) < 1) ? 1 : $clog2(N_TEAMS);
  logic [WIDTH-1:0] score [N_TEAMS];
  logic [N_TEAMS-1:0] hit;
  logic dz_prev;
  logic undo_acc;
  logic apply;
  logic single;
  logic [TEAM_W-1:0] hit_idx;
  logic [MAX_W-1:0] hit_score;
  logic [WIDTH-1:0] best;
  logic [LW-1:0] ld;
  logic tie;
  undo_t rec;

  assign undo_acc = bus.desfazer && !dz_prev && rec.valid && !bus.pr;
  assign apply = !bus.pr && !undo_acc;
  assign single = (hit & (hit - 1'b1)) == '0;

  for (genvar g = 0; g < N_TEAMS; g++) begin : g_canal
    placar_canal #(.WIDTH(WIDTH), .MAX_SCORE(MAX_SCORE)) u_canal (
      .clock(clock),
      .clr(clr),
      .field(bus.somaBTNs[PTS_W*g +: PTS_W]),
      .sub(bus.chaveNP),
      .apply_en(apply),
      .load_en(bus.pr || (undo_acc && rec.team == TEAM_W'(g))),
      .load_val(bus.pr ? WIDTH'(PRESET_VAL) : WIDTH'(rec.score)),
      .load_evt(!bus.pr),
      .score(score[g]),
      .evt(bus.evento[g]),
      .hit(hit[g])
    );
    assign bus.placar[WIDTH*g +: WIDTH] = score[g];
  end

  // locate the changing team and its pre-change score for the undo record
  always_comb begin
    hit_idx = '0;
    hit_score = '0;
    for (int i = 0; i < N_TEAMS; i++) begin
      hit_idx = hit[i] ? TEAM_W'(i) : hit_idx;
      hit_score = hit[i] ? MAX_W'(score[i]) : hit_score;
    end
  end

  // undo record and desfazer edge history
  always_ff @(posedge clock) begin
    if (clr) begin
      rec <= '0;
      dz_prev <= 1'b1;
    end else begin
      dz_prev <= bus.desfazer;
      if (bus.pr) rec <= '0;
      else if (undo_acc) rec.valid <= 1'b0;
      else if (hit != '0) rec <= '{valid: single, team: hit_idx, score: hit_score};
    end
  end

  // lowest-index maximum and whether that maximum is shared
  always_comb begin
    best = score[0];
    ld = '0;
    tie = 1'b0;
    for (int i = 1; i < N_TEAMS; i++) begin
      tie = (score[i] > best) ? 1'b0 : (score[i] == best) ? 1'b1 : tie;
      ld = (score[i] > best) ? LW'(i) : ld;
      best = (score[i] > best) ? score[i] : best;
    end
  end

  assign bus.lider = ld;
  assign bus.empate = tie;
endmodule

// File: tb/tb_placar_multitime.sv
// tb_placar_multitime: directed checks on a 2-team and a 4-team scoreboard
module tb_placar_multitime;
  logic clock = 1'b0;
  logic clr2;
  logic clr4;
  int errors = 0;
  int checks = 0;

  placar_multitime_if #(.N_TEAMS(2), .WIDTH(7)) b2 ();
  placar_multitime_if #(.N_TEAMS(4), .WIDTH(8)) b4 ();

  placar_multitime #(.N_TEAMS(2), .WIDTH(7), .MAX_SCORE(99), .PRESET_VAL(0)) d2 (
    .clock(clock), .clr(clr2), .bus(b2)
  );
  placar_multitime #(.N_TEAMS(4), .WIDTH(8), .MAX_SCORE(99), .PRESET_VAL(50)) d4 (
    .clock(clock), .clr(clr4), .bus(b4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic t2(input logic [3:0] f);
    b2.somaBTNs = f;
    tick();
  endtask

  task automatic t4(input logic [7:0] f);
    b4.somaBTNs = f;
    tick();
  endtask

  initial begin
    b2.pr = 0; b2.chaveNP = 0; b2.desfazer = 0; b2.somaBTNs = '0;
    b4.pr = 0; b4.chaveNP = 0; b4.desfazer = 0; b4.somaBTNs = '0;
    clr2 = 1; clr4 = 1;
    tick();
    clr2 = 0; clr4 = 0;
    chk("rst_placar", 32'(b2.placar), 32'h0);
    chk("rst_evento", 32'(b2.evento), 32'h0);
    chk("rst_lider", 32'(b2.lider), 32'h0);
    chk("rst_empate", 32'(b2.empate), 32'h1);
    tick();
    t2(4'b0010);
    chk("t0_plus2", 32'(b2.placar), 32'({7'd0, 7'd2}));
    chk("t0_ev1", 32'(b2.evento), 32'h1);
    t2(4'b0010);
    chk("t0_held_noev", 32'(b2.evento), 32'h0);
    t2(4'b0010);
    t2(4'b0000);
    t2(4'b0011);
    chk("t0_plus3", 32'(b2.placar), 32'({7'd0, 7'd5}));
    chk("t0_ev2", 32'(b2.evento), 32'h1);
    chk("t0_lider", 32'(b2.lider), 32'h0);
    chk("t0_empate", 32'(b2.empate), 32'h0);
    t2(4'b0000);
    t2(4'b0001);
    t2(4'b0011);
    chk("held_01_11", 32'(b2.placar), 32'({7'd0, 7'd6}));
    chk("held_01_11_ev", 32'(b2.evento), 32'h0);
    t2(4'b0000);
    for (int i = 0; i < 32; i++) begin
      t2(4'b1100);
      t2(4'b0000);
    end
    t2(4'b1000);
    t2(4'b0000);
    chk("t1_98", 32'(b2.placar), 32'({7'd98, 7'd6}));
    chk("t1_lider", 32'(b2.lider), 32'h1);
    t2(4'b1100);
    chk("sat_99", 32'(b2.placar), 32'({7'd99, 7'd6}));
    chk("sat_99_ev", 32'(b2.evento), 32'h2);
    t2(4'b0000);
    t2(4'b0100);
    chk("sat_stay", 32'(b2.placar), 32'({7'd99, 7'd6}));
    chk("sat_stay_noev", 32'(b2.evento), 32'h0);
    t2(4'b0000);
    b2.chaveNP = 1;
    t2(4'b0011);
    t2(4'b0000);
    t2(4'b0001);
    chk("sub_to_2", 32'(b2.placar), 32'({7'd99, 7'd2}));
    t2(4'b0000);
    t2(4'b0011);
    chk("sub_floor0", 32'(b2.placar), 32'({7'd99, 7'd0}));
    chk("sub_floor0_ev", 32'(b2.evento), 32'h1);
    t2(4'b0000);
    t2(4'b1100);
    chk("sub_t1_96", 32'(b2.placar), 32'({7'd96, 7'd0}));
    t2(4'b0000);
    b2.chaveNP = 0;
    t2(4'b0101);
    chk("simul_placar", 32'(b2.placar), 32'({7'd97, 7'd1}));
    chk("simul_ev", 32'(b2.evento), 32'h3);
    b2.somaBTNs = 4'b0000;
    b2.desfazer = 1;
    tick();
    chk("undo_invalid", 32'(b2.placar), 32'({7'd97, 7'd1}));
    chk("undo_invalid_ev", 32'(b2.evento), 32'h0);
    b2.desfazer = 0;
    t2(4'b1000);
    chk("t1_plus2", 32'(b2.placar), 32'({7'd99, 7'd1}));
    t2(4'b0000);
    b2.desfazer = 1;
    tick();
    chk("undo_restore", 32'(b2.placar), 32'({7'd97, 7'd1}));
    chk("undo_ev", 32'(b2.evento), 32'h2);
    b2.desfazer = 0;
    tick();
    b2.desfazer = 1;
    tick();
    chk("undo_twice", 32'(b2.placar), 32'({7'd97, 7'd1}));
    chk("undo_twice_ev", 32'(b2.evento), 32'h0);
    b2.desfazer = 0;
    t2(4'b0100);
    t2(4'b0000);
    chk("t1_98_again", 32'(b2.placar), 32'({7'd98, 7'd1}));
    b2.desfazer = 1;
    t2(4'b0010);
    chk("undo_vs_press", 32'(b2.placar), 32'({7'd97, 7'd1}));
    chk("undo_vs_press_ev", 32'(b2.evento), 32'h2);
    b2.desfazer = 0;
    t2(4'b0010);
    chk("press_lost", 32'(b2.placar), 32'({7'd97, 7'd1}));
    t2(4'b0000);
    t2(4'b0010);
    chk("press_rearm", 32'(b2.placar), 32'({7'd97, 7'd3}));
    chk("press_rearm_ev", 32'(b2.evento), 32'h1);
    t2(4'b0000);

    b4.pr = 1;
    tick();
    b4.pr = 0;
    chk("pr_all50", 32'(b4.placar), 32'h32323232);
    chk("pr_noev", 32'(b4.evento), 32'h0);
    chk("pr_empate", 32'(b4.empate), 32'h1);
    chk("pr_lider", 32'(b4.lider), 32'h0);
    t4(8'b0001_0000);
    chk("t2_plus1", 32'(b4.placar), 32'h32333232);
    chk("t2_ev", 32'(b4.evento), 32'h4);
    chk("t2_lider", 32'(b4.lider), 32'h2);
    chk("t2_empate", 32'(b4.empate), 32'h0);
    t4(8'b0000_0000);
    clr4 = 1;
    t4(8'b1100_0000);
    clr4 = 0;
    chk("clr_placar", 32'(b4.placar), 32'h0);
    chk("clr_ev", 32'(b4.evento), 32'h0);
    t4(8'b1100_0000);
    t4(8'b1100_0000);
    chk("clr_held", 32'(b4.placar), 32'h0);
    t4(8'b0000_0000);
    t4(8'b1100_0000);
    chk("clr_rearm", 32'(b4.placar), 32'h03000000);
    chk("clr_rearm_ev", 32'(b4.evento), 32'h8);
    chk("clr_rearm_lider", 32'(b4.lider), 32'h3);
    t4(8'b0000_0000);
    b4.pr = 1;
    tick();
    b4.pr = 0;
    b4.desfazer = 1;
    tick();
    chk("pr_clears_undo", 32'(b4.placar), 32'h32323232);
    chk("pr_clears_undo_ev", 32'(b4.evento), 32'h0);
    b4.desfazer = 0;
    t4(8'b0100_0100);
    chk("tie_placar", 32'(b4.placar), 32'h33323332);
    chk("tie_lider", 32'(b4.lider), 32'h1);
    chk("tie_empate", 32'(b4.empate), 32'h1);
    chk("tie_ev", 32'(b4.evento), 32'ha);
    t4(8'b0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
